// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS write-back path.
package mips_pkg;
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_LINK = 2'b10;
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;
  localparam logic [1:0] LOAD_WORD = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_BYTE = 2'b10;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/load_extend.sv
// load_extend: big-endian lane select and sign/zero extension of loaded data.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  addr,
  input  logic [1:0]  load_size,
  input  logic        load_unsigned,
  output logic [31:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  // ~addr maps byte 0 to bits [31:24]; halfword ignores addr[0]
  assign b = mem_data[{~addr, 3'b000} +: 8];
  assign h = addr[1] ? mem_data[15:0] : mem_data[31:16];
  always_comb
    data = load_size == LOAD_BYTE ? {{24{~load_unsigned & b[7]}}, b}
         : load_size == LOAD_HALF ? {{16{~load_unsigned & h[15]}}, h}
         : mem_data;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MIPS write-back with one main entry and one skid entry
// driving the register-file write port and a forwarding tap.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regWrite,
  input  logic [1:0]        in_regDst,
  input  logic [1:0]        in_memToReg,
  input  logic [1:0]        in_loadSize,
  input  logic              in_loadUnsigned,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_memData,
  input  logic [DATA_W-1:0] in_pcPlus4,
  input  logic              rfReady,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              fwdValid,
  output logic [ADDR_W-1:0] fwdAddress,
  output logic [DATA_W-1:0] fwdData,
  output logic [31:0]       retireCount
);
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;
  entry_t main_q, main_d, skid_q, skid_d, new_e;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, ready_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ld;
  logic acc, ret;
  load_extend u_ld (
    .mem_data(in_memData[31:0]),
    .addr(in_aluResult[1:0]),
    .load_size(in_loadSize),
    .load_unsigned(in_loadUnsigned),
    .data(ld)
  );
  always_comb begin
    new_e.addr = in_regDst == REGDST_RD ? in_rd
               : in_regDst == REGDST_LINK ? ADDR_W'(LINK_REG) : in_rt;
    new_e.data = in_memToReg == MEMTOREG_MEM ? DATA_W'(ld)
               : in_memToReg == MEMTOREG_LINK ? in_pcPlus4 : in_aluResult;
    new_e.we = in_regWrite && new_e.addr != ADDR_W'(REG_ZERO);
  end
  assign acc = in_valid && ready_q;
  assign ret = main_v_q && rfReady;
  // Main entry fields are never cleared on retire so the port holds its last value.
  always_comb begin
    main_v_d = main_v_q;
    main_d = main_q;
    skid_v_d = skid_v_q;
    skid_d = skid_q;
    if (ret) begin
      main_v_d = skid_v_q | acc;
      main_d = skid_v_q ? skid_q : acc ? new_e : main_q;
      skid_v_d = skid_v_q & acc;
      skid_d = skid_v_q & acc ? new_e : skid_q;
    end else if (acc && main_v_q) begin
      skid_v_d = 1'b1;
      skid_d = new_e;
    end else if (acc) begin
      main_v_d = 1'b1;
      main_d = new_e;
    end
    cnt_d = cnt_q + 32'(ret);
  end
  always_ff @(posedge clk)
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      ready_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
      ready_q <= !skid_v_d;
      cnt_q <= cnt_d;
    end
  assign in_ready = ready_q;
  assign regWrite = main_v_q && main_q.we;
  assign writeAddress = main_q.addr;
  assign writeData = main_q.data;
  assign fwdValid = regWrite;
  assign fwdAddress = main_q.addr;
  assign fwdData = main_q.data;
  assign retireCount = cnt_q;
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MIPS Write Back stage. It is the producer side of the register-file write port that the Instruction Decode stage consumes (regWrite / writeAddress / writeData).
- Accepts retiring instructions from the MEM/WB boundary through a valid/ready handshake.
- Selects and extends the result, resolves the destination register, suppresses writes to $0, and drives the register-file write port plus a forwarding tap.
- Holds one pipeline entry plus one skid entry, so it can absorb register-file back-pressure without losing instructions.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, register address width.
- LINK_REG, 31, destination register for link writes (jal/jalr).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_regWrite  in  1  instruction writes a register.
- in_regDst  in  2  00 = rt, 01 = rd, 10 = LINK_REG, 11 = rt.
- in_memToReg  in  2  00 = ALU result, 01 = load data, 10 = pcPlus4 (link), 11 = ALU result.
- in_loadSize  in  2  00 = word, 01 = half, 10 = byte, 11 = word.
- in_loadUnsigned  in  1  zero-extend (1) or sign-extend (0) sub-word loads.
- in_rt, in_rd  in  5 each  register fields.
- in_aluResult  in  32  ALU result / effective address.
- in_memData  in  32  data-memory read word.
- in_pcPlus4  in  32  link value.
- rfReady  in  1  register file accepts a write this cycle.
- regWrite  out  1  write enable to the register file.
- writeAddress  out  5  destination register.
- writeData  out  32  value to write.
- fwdValid  out  1  main entry holds a pending nonzero-register write.
- fwdAddress  out  5  same as writeAddress.
- fwdData  out  32  same as writeData.
- retireCount  out  32  instructions retired since reset.

Behaviour:
- Reset: main and skid entries invalid; regWrite = 0, writeAddress = 0, writeData = 0, fwdValid = 0, retireCount = 0, in_ready = 0. in_ready becomes 1 in the first cycle after reset deasserts. Reset asserted mid-operation discards both entries with no write issued.
- Accept: a transfer occurs on a posedge where in_valid && in_ready.
- Result formation (combinational at the input, stored already final in the entry):
  - Write address chosen by in_regDst.
  - Data chosen by in_memToReg.
  - Loads are big-endian. Byte lane 0 = in_memData[31:24], selected by in_aluResult[1:0].
  - Halfword: in_aluResult[1] = 0 selects [31:16], 1 selects [15:0]; in_aluResult[0] is ignored (no misalignment trap).
  - Extension of sub-word loads per in_loadUnsigned.
- Write-enable formation: stored we = in_regWrite && (address != 0).
- Retire:
  - Main entry valid → writeAddress / writeData driven from it; regWrite = we while main is valid; fwdValid = regWrite.
  - The entry retires on a posedge with rfReady = 1, whether or not we is set; retireCount increments by 1, wrapping modulo 2^32.
  - With rfReady = 0 the entry holds, and its outputs stay stable.
- Latency: an instruction accepted at edge k drives the write port during cycle k+1 and commits at edge k+1 if rfReady.
- Ordering:
  - On a retire edge, skid (if valid) moves into main; otherwise a new transfer goes to main.
  - A transfer arriving while main is valid and not retiring goes to skid.
  - Simultaneous retire + transfer with skid valid: skid → main, new → skid.
- in_ready (next) = !skid_valid after the edge update, so a transfer is never lost when rfReady drops.
- Invalid main entry: regWrite = 0; writeAddress / writeData hold their last value (not X).

Decomposition:
- Shared package mips_pkg: encodings REGDST_RT/RD/LINK, MEMTOREG_ALU/MEM/LINK, LOAD_WORD/HALF/BYTE, and the REG_ZERO constant.
- One sub-module, load_extend: combinational lane select plus sign/zero extension (inputs memData, addr[1:0], loadSize, unsigned).

Test Plan:
- R-type: regDst = 01, rd = 8, memToReg = 00, aluResult = 0x0000002A, rfReady = 1 → next cycle regWrite = 1, writeAddress = 8, writeData = 0x2A; retireCount = 1 after the edge.
- Loads: memData = 0x80FF7F01, loadSize = byte, addr = 0, signed → 0xFFFFFF80; same unsigned → 0x00000080; half, addr = 2, signed → 0x00007F01; addr = 1, half → 0xFFFF80FF.
- Link and $0: memToReg = 10, regDst = 10, pcPlus4 = 0x00400010 → write to r31 = 0x00400010. Then regDst = 01, rd = 0 → regWrite = 0, fwdValid = 0, retireCount still increments.
- Back-pressure: rfReady = 0 for 3 cycles while 3 instructions are offered back-to-back (rd = 1, 2, 3) → accepts 2, in_ready = 0 on the third. On rfReady = 1, writes occur in order r1, r2, r3 with no loss or duplication.
- Reset mid-operation: main and skid full, assert reset for 1 cycle → regWrite = 0, retireCount = 0, in_ready = 0 during reset and 1 the next cycle; no stale writes afterward.
